// File: rtl/ext_mem_bus_ctrl.sv
// Asynchronous SRAM/NOR bus controller: single read/write transfers with programmable setup/pulse/hold.
// Ack arrives SETUP+PULSE+HOLD+1 cycles after acceptance; new requests are ignored while busy.
module ext_mem_bus_ctrl #(
  parameter int DW        = 16,
  parameter int AW        = 22,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 6,
  parameter int HOLD_CYC  = 1,
  parameter int CNT_W     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            wr,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] be,
  output logic            busy,
  output logic            ack,
  output logic [DW-1:0]   rdata,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_dq_o,
  output logic            mem_dq_oe,
  input  logic [DW-1:0]   mem_dq_i,
  output logic            mem_ce_n,
  output logic            mem_we_n,
  output logic            mem_oe_n,
  output logic [DW/8-1:0] mem_be_n
);

  localparam int BW = DW / 8;

  // Counter reload values: each state runs from (length-1) down to zero.
  localparam logic [CNT_W-1:0] S_LD = (SETUP_CYC > 0) ? CNT_W'(SETUP_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] P_LD = (PULSE_CYC > 0) ? CNT_W'(PULSE_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] H_LD = (HOLD_CYC > 0)  ? CNT_W'(HOLD_CYC - 1)  : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic [DW-1:0]    lane_mask;

  // be_n is held for the whole transfer, so it doubles as the latched byte enables.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BW; i++) begin
      lane_mask[i*8 +: 8] = {8{~mem_be_n[i]}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_dq_o  <= '0;
      mem_dq_oe <= 1'b0;
      mem_ce_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
      mem_be_n  <= '1;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (be == '0) begin
              ack <= 1'b1;
            end else begin
              wr_q     <= wr;
              mem_addr <= addr;
              mem_be_n <= ~be;
              mem_ce_n <= 1'b0;
              busy     <= 1'b1;
              if (wr) begin
                mem_dq_o  <= wdata;
                mem_dq_oe <= 1'b1;
              end
              if (SETUP_CYC > 0) begin
                state <= SETUP;
                cnt   <= S_LD;
              end else begin
                state    <= PULSE;
                cnt      <= P_LD;
                mem_we_n <= ~wr;
                mem_oe_n <= wr;
              end
            end
          end
        end

        SETUP: begin
          if (cnt == '0) begin
            state    <= PULSE;
            cnt      <= P_LD;
            mem_we_n <= ~wr_q;
            mem_oe_n <= wr_q;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        PULSE: begin
          if (cnt == '0) begin
            mem_we_n <= 1'b1;
            mem_oe_n <= 1'b1;
            // Data is sampled at the strobe's rising edge, end of the last pulse cycle.
            if (!wr_q) begin
              rdata <= mem_dq_i & lane_mask;
            end
            if (HOLD_CYC > 0) begin
              state <= HOLD;
              cnt   <= H_LD;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              ack       <= 1'b1;
              mem_ce_n  <= 1'b1;
              mem_be_n  <= '1;
              mem_dq_oe <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        HOLD: begin
          if (cnt == '0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ack       <= 1'b1;
            mem_ce_n  <= 1'b1;
            mem_be_n  <= '1;
            mem_dq_oe <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_bus_ctrl.sv
// Directed bench: default-timing instance (a) with a small memory model, plus a 0/2/0 timing instance (b).
module tb_ext_mem_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_a, req_b, wr;
  logic [21:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;

  logic        busy_a, ack_a, dq_oe_a, ce_n_a, we_n_a, oe_n_a;
  logic [15:0] rdata_a, dq_o_a, dq_i_a;
  logic [21:0] mem_addr_a;
  logic [1:0]  be_n_a;

  logic        busy_b, ack_b, dq_oe_b, ce_n_b, we_n_b, oe_n_b;
  logic [15:0] rdata_b, dq_o_b, dq_i_b;
  logic [21:0] mem_addr_b;
  logic [1:0]  be_n_b;

  ext_mem_bus_ctrl u_a (
    .clk(clk), .rst(rst), .req(req_a), .wr(wr), .addr(addr), .wdata(wdata), .be(be),
    .busy(busy_a), .ack(ack_a), .rdata(rdata_a), .mem_addr(mem_addr_a),
    .mem_dq_o(dq_o_a), .mem_dq_oe(dq_oe_a), .mem_dq_i(dq_i_a),
    .mem_ce_n(ce_n_a), .mem_we_n(we_n_a), .mem_oe_n(oe_n_a), .mem_be_n(be_n_a)
  );

  ext_mem_bus_ctrl #(.SETUP_CYC(0), .PULSE_CYC(2), .HOLD_CYC(0)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .wr(wr), .addr(addr), .wdata(wdata), .be(be),
    .busy(busy_b), .ack(ack_b), .rdata(rdata_b), .mem_addr(mem_addr_b),
    .mem_dq_o(dq_o_b), .mem_dq_oe(dq_oe_b), .mem_dq_i(dq_i_b),
    .mem_ce_n(ce_n_b), .mem_we_n(we_n_b), .mem_oe_n(oe_n_b), .mem_be_n(be_n_b)
  );

  // Byte-lane memory behind instance a; instance b always returns 0xBEEF.
  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (!we_n_a) begin
      for (int i = 0; i < 2; i++) begin
        if (!be_n_a[i]) mem[mem_addr_a[3:0]][i*8 +: 8] <= dq_o_a[i*8 +: 8];
      end
    end
  end
  assign dq_i_a = oe_n_a ? 16'h0000 : mem[mem_addr_a[3:0]];
  assign dq_i_b = oe_n_b ? 16'h0000 : 16'hBEEF;

  // Negedge monitor on instance a; sample index 1 is the cycle right after the accepting edge.
  logic        mon_clr, a_wr_chk, a_seen_low;
  logic [15:0] exp_dq_a;
  int a_cyc, a_ce_lo, a_ce_first, a_we_lo, a_we_first, a_oe_lo;
  int a_ack_cnt, a_ack_at, a_dq_bad, a_viol, a_hi_run, a_gap;

  always @(negedge clk) begin
    if (mon_clr) begin
      a_cyc = 0; a_ce_lo = 0; a_ce_first = 0; a_we_lo = 0; a_we_first = 0; a_oe_lo = 0;
      a_ack_cnt = 0; a_ack_at = 0; a_dq_bad = 0; a_viol = 0; a_hi_run = 0; a_gap = 99;
      a_seen_low = 1'b0;
    end else begin
      a_cyc = a_cyc + 1;
      if (!ce_n_a) begin
        a_ce_lo = a_ce_lo + 1;
        if (a_ce_first == 0) a_ce_first = a_cyc;
        if (a_seen_low && a_hi_run > 0 && a_hi_run < a_gap) a_gap = a_hi_run;
        a_hi_run = 0;
        a_seen_low = 1'b1;
        if (a_wr_chk && (dq_oe_a !== 1'b1 || dq_o_a !== exp_dq_a)) a_dq_bad = a_dq_bad + 1;
      end else begin
        a_hi_run = a_hi_run + 1;
      end
      if (!we_n_a) begin
        a_we_lo = a_we_lo + 1;
        if (a_we_first == 0) a_we_first = a_cyc;
      end
      if (!oe_n_a) a_oe_lo = a_oe_lo + 1;
      if ((!we_n_a && !oe_n_a) || (!oe_n_a && dq_oe_a)) a_viol = a_viol + 1;
      if (ack_a) begin
        a_ack_cnt = a_ack_cnt + 1;
        a_ack_at = a_cyc;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack_a(input int max);
    int n;
    n = 0;
    while (ack_a !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check("ack_wait", 32'(ack_a), 32'h1);
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
    mon_clr = 1'b1; a_wr_chk = 1'b0; exp_dq_a = '0;
    tick(); tick();
    check("rst_ce",    32'(ce_n_a),  32'h1);
    check("rst_we",    32'(we_n_a),  32'h1);
    check("rst_oe",    32'(oe_n_a),  32'h1);
    check("rst_be_n",  32'(be_n_a),  32'h3);
    check("rst_dq_oe", 32'(dq_oe_a), 32'h0);
    check("rst_busy",  32'(busy_a),  32'h0);
    check("rst_ack",   32'(ack_a),   32'h0);
    check("rst_rdata", 32'(rdata_a), 32'h0);
    check("rst_b_ce",  32'(ce_n_b),  32'h1);
    rst = 1'b0;
    tick();

    // Write with default timing: 1 setup, 6 pulse, 1 hold.
    a_wr_chk = 1'b1; exp_dq_a = 16'hA55A;
    req_a = 1'b1; wr = 1'b1; addr = 22'h12345; wdata = 16'hA55A; be = 2'b11;
    tick();
    mon_clr = 1'b0; req_a = 1'b0;
    check("wr_busy",  32'(busy_a), 32'h1);
    check("wr_ce_lo", 32'(ce_n_a), 32'h0);
    repeat (12) tick();
    check("wr_ce_cnt",   32'(a_ce_lo),    32'd8);
    check("wr_ce_first", 32'(a_ce_first), 32'd1);
    check("wr_we_cnt",   32'(a_we_lo),    32'd6);
    check("wr_we_first", 32'(a_we_first), 32'd2);
    check("wr_oe_cnt",   32'(a_oe_lo),    32'd0);
    check("wr_ack_cnt",  32'(a_ack_cnt),  32'd1);
    check("wr_ack_at",   32'(a_ack_at),   32'd9);
    check("wr_dq",       32'(a_dq_bad),   32'd0);
    check("wr_addr",     32'(mem_addr_a), 32'h12345);
    check("wr_dq_oe_off", 32'(dq_oe_a),   32'h0);
    check("wr_dq_keep",  32'(dq_o_a),     32'hA55A);
    check("wr_be_n_off", 32'(be_n_a),     32'h3);
    check("wr_busy_off", 32'(busy_a),     32'h0);
    a_wr_chk = 1'b0;
    mon_clr = 1'b1;

    // Read on the fast instance: strobe low for two cycles, only the upper lane enabled.
    req_b = 1'b1; wr = 1'b0; addr = 22'h00100; be = 2'b10;
    tick();
    req_b = 1'b0;
    check("rd_oe_lo0", 32'(oe_n_b),  32'h0);
    check("rd_we",     32'(we_n_b),  32'h1);
    check("rd_ce",     32'(ce_n_b),  32'h0);
    check("rd_dq_oe",  32'(dq_oe_b), 32'h0);
    check("rd_be_n",   32'(be_n_b),  32'h1);
    check("rd_ack0",   32'(ack_b),   32'h0);
    tick();
    check("rd_oe_lo1", 32'(oe_n_b),  32'h0);
    check("rd_ack1",   32'(ack_b),   32'h0);
    tick();
    check("rd_oe_hi",  32'(oe_n_b),  32'h1);
    check("rd_ce_hi",  32'(ce_n_b),  32'h1);
    check("rd_ack",    32'(ack_b),   32'h1);
    check("rd_busy",   32'(busy_b),  32'h0);
    check("rd_rdata",  32'(rdata_b), 32'hBE00);
    tick();
    check("rd_ack_pulse", 32'(ack_b),   32'h0);
    check("rd_hold",      32'(rdata_b), 32'hBE00);

    // Back-to-back: write, then a read of the same word issued in the ack cycle.
    req_a = 1'b1; wr = 1'b1; addr = 22'h3; wdata = 16'h1234; be = 2'b11;
    tick();
    mon_clr = 1'b0; req_a = 1'b0;
    wait_ack_a(20);
    req_a = 1'b1; wr = 1'b0; addr = 22'h3; be = 2'b11;
    tick();
    req_a = 1'b0;
    check("b2b_start_ce", 32'(ce_n_a), 32'h0);
    check("b2b_start_busy", 32'(busy_a), 32'h1);
    wait_ack_a(20);
    tick();
    check("b2b_rdata", 32'(rdata_a),   32'h1234);
    check("b2b_gap",   32'(a_gap),     32'd1);
    check("b2b_viol",  32'(a_viol),    32'd0);
    check("b2b_acks",  32'(a_ack_cnt), 32'd2);
    check("b2b_we",    32'(a_we_lo),   32'd6);
    check("b2b_oe",    32'(a_oe_lo),   32'd6);
    mon_clr = 1'b1;

    // Request with no byte lanes: immediate ack, no bus activity.
    req_a = 1'b1; wr = 1'b0; addr = 22'h4; be = 2'b00;
    tick();
    mon_clr = 1'b0; req_a = 1'b0;
    check("be0_ack",  32'(ack_a),  32'h1);
    check("be0_busy", 32'(busy_a), 32'h0);
    check("be0_ce",   32'(ce_n_a), 32'h1);
    tick();
    check("be0_ack_pulse", 32'(ack_a), 32'h0);
    repeat (3) tick();
    check("be0_ce_cnt", 32'(a_ce_lo), 32'd0);
    check("be0_rdata",  32'(rdata_a), 32'h1234);
    mon_clr = 1'b1;

    // A request pulsed mid-transfer is ignored.
    a_wr_chk = 1'b1; exp_dq_a = 16'h5555;
    req_a = 1'b1; wr = 1'b1; addr = 22'h9; wdata = 16'h5555; be = 2'b01;
    tick();
    mon_clr = 1'b0; req_a = 1'b0;
    tick(); tick();
    req_a = 1'b1; wr = 1'b0; addr = 22'hA; be = 2'b11;
    tick();
    req_a = 1'b0;
    repeat (14) tick();
    check("busy_acks",  32'(a_ack_cnt),  32'd1);
    check("busy_addr",  32'(mem_addr_a), 32'h9);
    check("busy_ce",    32'(a_ce_lo),    32'd8);
    check("busy_dq",    32'(a_dq_bad),   32'd0);
    a_wr_chk = 1'b0;
    mon_clr = 1'b1;

    // Reset during the write pulse aborts the transfer.
    req_a = 1'b1; wr = 1'b1; addr = 22'h7; wdata = 16'hCAFE; be = 2'b11;
    tick();
    mon_clr = 1'b0; req_a = 1'b0;
    tick(); tick(); tick();
    check("abort_in_pulse", 32'(we_n_a), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_we",    32'(we_n_a),  32'h1);
    check("abort_ce",    32'(ce_n_a),  32'h1);
    check("abort_busy",  32'(busy_a),  32'h0);
    check("abort_dq_oe", 32'(dq_oe_a), 32'h0);
    repeat (12) tick();
    check("abort_no_ack", 32'(a_ack_cnt), 32'd0);
    mon_clr = 1'b1;
    req_a = 1'b1; wr = 1'b1; addr = 22'h8; wdata = 16'h0F0F; be = 2'b11;
    tick();
    mon_clr = 1'b0; req_a = 1'b0;
    repeat (12) tick();
    check("after_abort_acks", 32'(a_ack_cnt),  32'd1);
    check("after_abort_at",   32'(a_ack_at),   32'd9);
    check("after_abort_addr", 32'(mem_addr_a), 32'h8);
    check("after_abort_we",   32'(a_we_lo),    32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
